// File: rtl/tdc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : tdc_pkg                                                      |
// | Description : Shared constants for the TDC event buffer: default field     |
// |               widths, field offsets inside the packed event word, and a    |
// |               helper that returns the event word width.                    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package tdc_pkg;

  localparam int DEF_FINE_W   = 5;
  localparam int DEF_COARSE_W = 4;

  // Event word packing, MSB to LSB: {timestamp, coarse, fine}
  localparam int FINE_LSB   = 0;
  localparam int COARSE_LSB = DEF_FINE_W;
  localparam int TS_LSB     = DEF_FINE_W + DEF_COARSE_W;

  function automatic int event_w(input int ts_w);
    return ts_w + DEF_COARSE_W + DEF_FINE_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tdc_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tdc_sync_fifo                                                |
// | Description : Generic single-clock FIFO with registered read data, a       |
// |               one-cycle read-valid pulse and registered level/full/empty.  |
// |               A write while full is accepted only if a read is accepted in |
// |               the same cycle. No fall-through.                             |
// | Ports       : clk, rst_n      clock, async active-low reset                |
// |               i_wr_en/i_wr_data   write request and data                   |
// |               i_rd_en             read request                             |
// |               o_rd_data/o_rd_valid  read data (held) and valid pulse       |
// |               o_empty/o_full/o_level  occupancy status                     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tdc_sync_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_rd_valid,
  output logic             o_empty,
  output logic             o_full,
  output logic [LW-1:0]    o_level
);

  localparam logic [LW-1:0] c_DEPTH = LW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             r_empty;
  logic             r_full;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_valid;

  logic             w_rd_acc;
  logic             w_wr_acc;
  logic [LW-1:0]    w_level_nxt;

  // A read frees a slot in the same edge, so a full FIFO can still take a write
  // when a read is accepted alongside it.
  assign w_rd_acc = i_rd_en & ~r_empty;
  assign w_wr_acc = i_wr_en & (~r_full | w_rd_acc);

  always_comb begin
    w_level_nxt = r_level;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_level_nxt = r_level + LW'(1);
      2'b01:   w_level_nxt = r_level - LW'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  // Storage has no reset; contents are meaningless until written. When full,
  // wr_ptr == rd_ptr and the read picks up the old word before it is replaced.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr  <= r_rd_ptr + AW'(1);
        r_rd_data <= r_mem[r_rd_ptr];
      end
      r_level <= w_level_nxt;
      r_empty <= (w_level_nxt == '0);
      r_full  <= (w_level_nxt == c_DEPTH);
    end
  end

  assign o_rd_data  = r_rd_data;
  assign o_rd_valid = r_rd_valid;
  assign o_empty    = r_empty;
  assign o_full     = r_full;
  assign o_level    = r_level;

endmodule
`default_nettype wire

// File: rtl/tdc_event_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tdc_event_buffer                                             |
// | Description : Timestamps each TDC measurement with a free-running cycle    |
// |               counter, packs {timestamp, coarse, fine} into a FIFO and     |
// |               counts measurements dropped while the FIFO is full.          |
// | Ports       : clk, rst_n                 clock, async active-low reset     |
// |               i_tdc_valid/i_bin_out/i_out_count  TDC measurement           |
// |               i_rd_en, o_dout, o_dout_valid      readout side              |
// |               o_empty/o_full/o_level             FIFO status               |
// |               o_lost_cnt, i_clr_lost              saturating drop counter  |
// |               o_ts_wrap                           timestamp wrap pulse     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tdc_event_buffer
  import tdc_pkg::*;
#(
  parameter int FINE_W   = DEF_FINE_W,
  parameter int COARSE_W = DEF_COARSE_W,
  parameter int TS_W     = 16,
  parameter int DEPTH    = 16,
  parameter int LOST_W   = 8,
  localparam int EW      = TS_W + COARSE_W + FINE_W,
  localparam int LW      = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_tdc_valid,
  input  logic [FINE_W-1:0]   i_bin_out,
  input  logic [COARSE_W-1:0] i_out_count,
  input  logic                i_rd_en,
  output logic [EW-1:0]       o_dout,
  output logic                o_dout_valid,
  output logic                o_empty,
  output logic                o_full,
  output logic [LW-1:0]       o_level,
  output logic [LOST_W-1:0]   o_lost_cnt,
  input  logic                i_clr_lost,
  output logic                o_ts_wrap
);

  localparam logic [LOST_W-1:0] c_LOST_MAX = '1;

  logic [TS_W-1:0]   r_ts;
  logic              r_ts_wrap;
  logic [LOST_W-1:0] r_lost_cnt;

  logic [EW-1:0]     w_word;
  logic              w_empty;
  logic              w_full;
  logic              w_drop;

  assign w_word = {r_ts, i_out_count, i_bin_out};

  // Same acceptance rule as the FIFO: a strobe is lost only when full and no
  // read is taken in the same cycle.
  assign w_drop = i_tdc_valid & w_full & ~(i_rd_en & ~w_empty);

  tdc_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wr_en    (i_tdc_valid),
    .i_wr_data  (w_word),
    .i_rd_en    (i_rd_en),
    .o_rd_data  (o_dout),
    .o_rd_valid (o_dout_valid),
    .o_empty    (w_empty),
    .o_full     (w_full),
    .o_level    (o_level)
  );

  // The wrap flag is registered from the all-ones value, so it is high in the
  // cycle where the counter reads 0 after wrapping, never right out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ts      <= '0;
      r_ts_wrap <= 1'b0;
    end else begin
      r_ts      <= r_ts + TS_W'(1);
      r_ts_wrap <= (r_ts == '1);
    end
  end

  // A clear coinciding with a drop keeps that drop: the count restarts at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lost_cnt <= '0;
    end else if (i_clr_lost) begin
      r_lost_cnt <= w_drop ? LOST_W'(1) : '0;
    end else if (w_drop && (r_lost_cnt != c_LOST_MAX)) begin
      r_lost_cnt <= r_lost_cnt + LOST_W'(1);
    end
  end

  assign o_empty    = w_empty;
  assign o_full     = w_full;
  assign o_lost_cnt = r_lost_cnt;
  assign o_ts_wrap  = r_ts_wrap;

endmodule
`default_nettype wire

// File: tb/tb_tdc_event_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_tdc_event_buffer                                          |
// | Description : Directed self-checking bench for tdc_event_buffer.           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_tdc_event_buffer;
  import tdc_pkg::*;

  localparam int TS_W = 16;
  localparam int EW   = event_w(TS_W);
  localparam int LW   = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tdc_valid = 1'b0;
  logic [4:0]    bin_out = '0;
  logic [3:0]    out_count = '0;
  logic          rd_en = 1'b0;
  logic          clr_lost = 1'b0;
  logic [EW-1:0] dout;
  logic          dout_valid;
  logic          empty;
  logic          full;
  logic [LW-1:0] level;
  logic [7:0]    lost_cnt;
  logic          ts_wrap;

  int total = 0;
  int bad   = 0;

  logic [TS_W-1:0] ts_m;
  logic [EW-1:0]   q [$];
  logic [EW-1:0]   last_w;
  logic [EW-1:0]   exp_w;
  int              wraps;

  tdc_event_buffer u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_tdc_valid  (tdc_valid),
    .i_bin_out    (bin_out),
    .i_out_count  (out_count),
    .i_rd_en      (rd_en),
    .o_dout       (dout),
    .o_dout_valid (dout_valid),
    .o_empty      (empty),
    .o_full       (full),
    .o_level      (level),
    .o_lost_cnt   (lost_cnt),
    .i_clr_lost   (clr_lost),
    .o_ts_wrap    (ts_wrap)
  );

  always #5 clk = ~clk;

  // Reference cycle counter: value in the current cycle is the stamp a strobe gets.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_m <= '0;
    else        ts_m <= ts_m + 16'd1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [EW-1:0] mk(input logic [15:0] ts, input logic [3:0] c, input logic [4:0] f);
    return {ts, c, f};
  endfunction

  initial begin
    // Reset values
    #20;
    chk("rst_dout", 32'(dout), 0);
    chk("rst_valid", 32'(dout_valid), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_lost", 32'(lost_cnt), 0);
    chk("rst_wrap", 32'(ts_wrap), 0);
    #2 rst_n = 1'b1;

    // 1: single event at ts=5
    repeat (5) begin
      tick();
      chk("t1_nowrap", 32'(ts_wrap), 0);
    end
    tdc_valid = 1'b1; out_count = 4'd3; bin_out = 5'd17;
    tick();
    tdc_valid = 1'b0;
    chk("t1_empty_after_wr", 32'(empty), 0);
    chk("t1_level_after_wr", 32'(level), 1);
    tick();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("t1_dout", 32'(dout), 32'({16'd5, 4'd3, 5'd17}));
    chk("t1_dout_valid", 32'(dout_valid), 1);
    chk("t1_empty_after_rd", 32'(empty), 1);
    chk("t1_level_after_rd", 32'(level), 0);
    tick();
    chk("t1_valid_pulse", 32'(dout_valid), 0);
    chk("t1_dout_hold", 32'(dout), 32'({16'd5, 4'd3, 5'd17}));

    // 2: fill, overflow by 3, drain in order
    tdc_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bin_out = 5'(i); out_count = 4'(15 - i);
      q.push_back(mk(ts_m, out_count, bin_out));
      tick();
    end
    chk("t2_full", 32'(full), 1);
    chk("t2_level16", 32'(level), 16);
    repeat (3) tick();
    tdc_valid = 1'b0;
    chk("t2_lost3", 32'(lost_cnt), 3);
    chk("t2_level_still16", 32'(level), 16);
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      exp_w = q.pop_front();
      chk("t2_drain_dout", 32'(dout), 32'(exp_w));
      chk("t2_drain_valid", 32'(dout_valid), 1);
    end
    rd_en = 1'b0;
    chk("t2_empty", 32'(empty), 1);
    chk("t2_full_clear", 32'(full), 0);

    // 3: write+read while full
    tdc_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bin_out = 5'(i + 8); out_count = 4'(i);
      q.push_back(mk(ts_m, out_count, bin_out));
      tick();
    end
    bin_out = 5'd31; out_count = 4'd15; rd_en = 1'b1;
    q.push_back(mk(ts_m, out_count, bin_out));
    tick();
    tdc_valid = 1'b0;
    exp_w = q.pop_front();
    chk("t3_dout_first", 32'(dout), 32'(exp_w));
    chk("t3_level16", 32'(level), 16);
    chk("t3_full", 32'(full), 1);
    chk("t3_lost_same", 32'(lost_cnt), 3);
    for (int i = 0; i < 16; i++) begin
      tick();
      exp_w = q.pop_front();
      chk("t3_drain_dout", 32'(dout), 32'(exp_w));
    end
    rd_en = 1'b0;
    last_w = exp_w;
    chk("t3_empty", 32'(empty), 1);

    // 4: reads while empty
    rd_en = 1'b1;
    tick();
    chk("t4_dout_hold", 32'(dout), 32'(last_w));
    chk("t4_novalid", 32'(dout_valid), 0);
    chk("t4_level0", 32'(level), 0);
    tdc_valid = 1'b1; bin_out = 5'd9; out_count = 4'd2;
    q.push_back(mk(ts_m, out_count, bin_out));
    tick();
    tdc_valid = 1'b0;
    chk("t4_dout_hold2", 32'(dout), 32'(last_w));
    chk("t4_novalid2", 32'(dout_valid), 0);
    chk("t4_level1", 32'(level), 1);
    chk("t4_notempty", 32'(empty), 0);
    tick();
    rd_en = 1'b0;
    exp_w = q.pop_front();
    chk("t4_readback", 32'(dout), 32'(exp_w));
    chk("t4_empty", 32'(empty), 1);

    // 5: saturation and clear-with-drop
    tdc_valid = 1'b1;
    repeat (316) tick();
    tdc_valid = 1'b0;
    chk("t5_lost_sat", 32'(lost_cnt), 255);
    tdc_valid = 1'b1; clr_lost = 1'b1;
    tick();
    tdc_valid = 1'b0;
    chk("t5_clr_drop", 32'(lost_cnt), 1);
    tick();
    clr_lost = 1'b0;
    chk("t5_clr", 32'(lost_cnt), 0);
    rd_en = 1'b1;
    repeat (16) tick();
    rd_en = 1'b0;
    chk("t5_empty", 32'(empty), 1);

    // 6: timestamp wrap, then async reset mid-burst
    wraps = 0;
    for (int i = 0; i < 65536; i++) begin
      tick();
      if (ts_wrap) begin
        wraps++;
        chk("t6_wrap_at0", 32'(ts_m), 0);
      end
    end
    chk("t6_wrap_once", wraps, 1);
    tdc_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bin_out = 5'(i + 1); out_count = 4'd5;
      q.push_back(mk(ts_m, out_count, bin_out));
      tick();
    end
    tdc_valid = 1'b0; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    exp_w = q.pop_front();
    chk("t6_dout_pre", 32'(dout), 32'(exp_w));
    chk("t6_level7", 32'(level), 7);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_async_empty", 32'(empty), 1);
    chk("t6_async_level", 32'(level), 0);
    chk("t6_async_dout", 32'(dout), 0);
    chk("t6_async_full", 32'(full), 0);
    q.delete();
    #2 rst_n = 1'b1;
    tick();
    tick();
    tdc_valid = 1'b1; bin_out = 5'd1; out_count = 4'd1;
    tick();
    tdc_valid = 1'b0; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("t6_restart_dout", 32'(dout), 32'({16'd2, 4'd1, 5'd1}));
    chk("t6_restart_level", 32'(level), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
